// File: rtl/adder_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// Holds the FSM encoding and the rotating-priority pick function.
package adder_pkg;

    localparam int ADD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    // First set bit in req scanning upward from last+1, wrapping at n.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] last,
        input int         n
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/full_adder_16b.sv
// Unsigned 16-bit adder with carry out.
// Shared datapath adder owned by adder_rr_arbiter.
module full_adder_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one full_adder_16b between requesters.
// Grant in IDLE, add in CALC, hold the tagged result in RESP.
module adder_rr_arbiter
    import adder_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = ADD_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH:0]           rsp_sum
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant;
    logic [7:0]       req_pad;
    logic [2:0]       pick;
    logic             hs;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    assign req_pad = 8'(req_valid);
    assign pick    = rr_pick(req_pad, 3'(last_grant), NUM_REQ);
    assign grant   = ID_W'(pick);

    // Gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && |req_valid) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign hs = |(req_valid & req_ready);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (hs) state_n = CALC;
            CALC:    state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            id_q       <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_id     <= '0;
            rsp_sum    <= '0;
        end else begin
            if (state == IDLE && hs) begin
                op_a       <= req_a[int'(grant)*WIDTH +: WIDTH];
                op_b       <= req_b[int'(grant)*WIDTH +: WIDTH];
                id_q       <= grant;
                last_grant <= grant;
            end
            if (state == CALC) begin
                rsp_sum <= {add_carry, add_sum};
                rsp_id  <= id_q;
            end
        end
    end

    assign rsp_valid = (state == RESP);

    full_adder_16b u_add (
        .a     (op_a),
        .b     (op_b),
        .sum   (add_sum),
        .carry (add_carry)
    );

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: per-requester expected queues
// plus an optional expected grant-order queue, checked by a monitor.
module tb_adder_rr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W:0]     rsp_sum;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    op_t         src_q[N][$];
    logic [16:0] exp_q[N][$];
    int          ord_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          issued    = 0;
    int          rsp_cnt   = 0;
    logic [N-1:0] acc      = '0;
    bit          rnd       = 1'b0;
    logic        rdy_level = 1'b1;
    bit          hold      = 1'b0;
    logic [16:0] h_sum;
    logic [1:0]  h_id;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic issue(int i, logic [15:0] a, logic [15:0] b,
                         logic [16:0] e);
        op_t o;
        o.a = a;
        o.b = b;
        src_q[i].push_back(o);
        exp_q[i].push_back(e);
        issued++;
    endtask

    function automatic bit all_empty();
        bit r;
        r = (ord_q.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic drain(int budget);
        int n;
        n = 0;
        while (!all_empty() && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_done", 32'(all_empty()), 1);
    endtask

    task automatic wait_acc(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) ok = 1'b1;
        end
    endtask

    // Requester drivers: hold each front operand until accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                req_valid[i]     = 1'b1;
                req_a[i*W +: W]  = src_q[i][0].a;
                req_b[i*W +: W]  = src_q[i][0].b;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        acc       = '0;
        rsp_ready = rnd ? 1'($urandom_range(0, 1)) : rdy_level;
    end

    // Response monitor and protocol checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
            acc  = '0;
        end else begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
            if (hold) begin
                chk("hold_valid", 32'(rsp_valid), 1);
                chk("hold_sum", 32'(rsp_sum), 32'(h_sum));
                chk("hold_id", 32'(rsp_id), 32'(h_id));
            end
            if (rsp_valid) begin
                chk("ready_in_resp", 32'(req_ready), 0);
                if (exp_q[rsp_id].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual id=%0d sum=%0h required none",
                             rsp_id, rsp_sum);
                end else if (rsp_ready) begin
                    chk("sum", 32'(rsp_sum), 32'(exp_q[rsp_id].pop_front()));
                    if (ord_q.size() > 0) chk("order", 32'(rsp_id), ord_q.pop_front());
                    rsp_cnt++;
                end
            end
            hold  = rsp_valid & !rsp_ready;
            h_sum = rsp_sum;
            h_id  = rsp_id;
            acc   = req_valid & req_ready;
        end
    end

    initial begin
        bit          ok;
        logic [15:0] a;
        logic [15:0] b;
        int          i;
        int          n;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

        // Single request and latency
        issue(0, 16'h1234, 16'h0001, 17'h01235);
        ord_q.push_back(0);
        wait_acc(ok);
        chk("single_acc", 32'(ok), 1);
        chk("single_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        chk("lat_calc", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("lat_resp", 32'(rsp_valid), 1);
        drain(100);

        // Carry boundary
        issue(2, 16'hffff, 16'hffff, 17'h1fffe);
        ord_q.push_back(2);
        drain(100);

        // Round robin from reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 16'h0100, 16'h0023, 17'h00123);
        issue(1, 16'h8000, 16'h8000, 17'h10000);
        issue(2, 16'h00ff, 16'h0001, 17'h00100);
        issue(3, 16'habcd, 16'h1111, 17'h0bcde);
        issue(0, 16'h7fff, 16'h0001, 17'h08000);
        ord_q = '{0, 1, 2, 3, 0};
        drain(200);

        // Backpressure
        rdy_level = 1'b0;
        issue(1, 16'h0f0f, 16'h0101, 17'h01010);
        issue(3, 16'hffff, 16'h0001, 17'h10000);
        ord_q = '{1, 3};
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        chk("bp_rsp_seen", 32'(ok), 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 0);
        end
        rdy_level = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) ok = 1'b1;
        end
        chk("bp_release", 32'(ok), 1);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'h8);
        drain(100);

        // Reset during CALC
        issue(1, 16'h0005, 16'h0006, 17'h0000b);
        wait_acc(ok);
        chk("mid_acc", 32'(ok), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q[1].delete();
        src_q[1].delete();
        ord_q.delete();
        issued--;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_req_ready", 32'(req_ready), 0);
        issue(2, 16'h4000, 16'h4000, 17'h08000);
        issue(0, 16'h0003, 16'h0004, 17'h00007);
        ord_q = '{0, 2};
        repeat (2) @(negedge clk);
        chk("rst_hold_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        drain(100);

        // Random soak
        rnd = 1'b1;
        for (n = 0; n < 1000; n++) begin
            i = $urandom_range(0, N - 1);
            a = 16'($urandom);
            b = 16'($urandom);
            issue(i, a, b, 17'(a) + 17'(b));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(20000);
        rnd = 1'b0;
        chk("rsp_count", 32'(rsp_cnt), 32'(issued));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
